// File: rtl/pe_array_os.sv
// Output-stationary ROWS x COLS systolic MAC array with internal operand skew,
// a flush/drain sequencer and valid/ready handshakes on operands and results.
module pe_array_os #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 24,
  parameter int KW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KW-1:0]      cfg_k,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ROWS*DW-1:0] a_data,
  input  logic [COLS*DW-1:0] w_data,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [COLS*AW-1:0] o_data,
  output logic               o_last
);
  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FCW = $clog2(FLUSH_LEN + 1);
  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} stateT;
  stateT state;

  logic [KW-1:0]  kReg, beatCnt;
  logic [FCW-1:0] flushCnt;
  logic [RIW-1:0] drainIdx;
  logic           startOk, en, tagIn;

  // The array only advances on an accepted beat or while flushing; flush beats carry cleared tags.
  assign startOk = (state == IDLE) && start && (cfg_k != '0);
  assign en      = ((state == COMPUTE) && in_valid) || (state == FLUSH);
  assign tagIn   = (state == COMPUTE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      kReg     <= '0;
      beatCnt  <= '0;
      flushCnt <= '0;
      drainIdx <= '0;
    end else begin
      case (state)
        IDLE: if (startOk) begin
          kReg    <= cfg_k;
          beatCnt <= '0;
          state   <= COMPUTE;
        end
        COMPUTE: if (in_valid) begin
          if (beatCnt == kReg - KW'(1)) begin
            beatCnt  <= '0;
            flushCnt <= '0;
            state    <= FLUSH;
          end else begin
            beatCnt <= beatCnt + KW'(1);
          end
        end
        FLUSH: begin
          if (flushCnt == FCW'(FLUSH_LEN - 1)) begin
            flushCnt <= '0;
            drainIdx <= '0;
            state    <= DRAIN;
          end else begin
            flushCnt <= flushCnt + FCW'(1);
          end
        end
        DRAIN: if (o_ready) begin
          if (drainIdx == RIW'(ROWS - 1)) begin
            drainIdx <= '0;
            state    <= IDLE;
          end else begin
            drainIdx <= drainIdx + RIW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [DW-1:0] aSkew [ROWS];
  logic                 aSkewV [ROWS];
  logic signed [DW-1:0] wSkew [COLS];
  logic                 wSkewV [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : gASkew
    logic signed [DW-1:0] laneIn;
    assign laneIn = tagIn ? $signed(a_data[r*DW +: DW]) : '0;
    if (r == 0) begin : gDirect
      assign aSkew[r]  = laneIn;
      assign aSkewV[r] = tagIn;
    end else begin : gDelay
      logic signed [DW-1:0] d [r];
      logic                 v [r];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < r; i++) begin
            d[i] <= '0;
            v[i] <= 1'b0;
          end
        end else if (startOk) begin
          for (int i = 0; i < r; i++) v[i] <= 1'b0;
        end else if (en) begin
          d[0] <= laneIn;
          v[0] <= tagIn;
          for (int i = 1; i < r; i++) begin
            d[i] <= d[i-1];
            v[i] <= v[i-1];
          end
        end
      end
      assign aSkew[r]  = d[r-1];
      assign aSkewV[r] = v[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : gWSkew
    logic signed [DW-1:0] laneIn;
    assign laneIn = tagIn ? $signed(w_data[c*DW +: DW]) : '0;
    if (c == 0) begin : gDirect
      assign wSkew[c]  = laneIn;
      assign wSkewV[c] = tagIn;
    end else begin : gDelay
      logic signed [DW-1:0] d [c];
      logic                 v [c];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < c; i++) begin
            d[i] <= '0;
            v[i] <= 1'b0;
          end
        end else if (startOk) begin
          for (int i = 0; i < c; i++) v[i] <= 1'b0;
        end else if (en) begin
          d[0] <= laneIn;
          v[0] <= tagIn;
          for (int i = 1; i < c; i++) begin
            d[i] <= d[i-1];
            v[i] <= v[i-1];
          end
        end
      end
      assign wSkew[c]  = d[c-1];
      assign wSkewV[c] = v[c-1];
    end
  end

  logic signed [DW-1:0] aReg [ROWS][COLS];
  logic signed [DW-1:0] wReg [ROWS][COLS];
  logic                 aV   [ROWS][COLS];
  logic                 wV   [ROWS][COLS];
  logic signed [AW-1:0] acc  [ROWS][COLS];

  // Each cell multiplies the operands it currently holds, so a cell fires one enable after both arrive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          aReg[r][c] <= '0;
          wReg[r][c] <= '0;
          aV[r][c]   <= 1'b0;
          wV[r][c]   <= 1'b0;
          acc[r][c]  <= '0;
        end
      end
    end else if (startOk) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          aV[r][c]  <= 1'b0;
          wV[r][c]  <= 1'b0;
          acc[r][c] <= '0;
        end
      end
    end else if (en) begin
      for (int r = 0; r < ROWS; r++) begin
        aReg[r][0] <= aSkew[r];
        aV[r][0]   <= aSkewV[r];
        for (int c = 1; c < COLS; c++) begin
          aReg[r][c] <= aReg[r][c-1];
          aV[r][c]   <= aV[r][c-1];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        wReg[0][c] <= wSkew[c];
        wV[0][c]   <= wSkewV[c];
        for (int r = 1; r < ROWS; r++) begin
          wReg[r][c] <= wReg[r-1][c];
          wV[r][c]   <= wV[r-1][c];
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (aV[r][c] && wV[r][c])
            acc[r][c] <= acc[r][c] + AW'(aReg[r][c]) * AW'(wReg[r][c]);
        end
      end
    end
  end

  assign busy     = (state != IDLE);
  assign in_ready = (state == COMPUTE);
  assign o_valid  = (state == DRAIN);
  assign o_last   = o_valid && (drainIdx == RIW'(ROWS - 1));

  always_comb begin
    o_data = '0;
    if (o_valid) begin
      for (int c = 0; c < COLS; c++) o_data[c*AW +: AW] = acc[drainIdx][c];
    end
  end
endmodule

// File: tb/tb_pe_array_os.sv
// Scoreboard bench for pe_array_os: expected result rows are queued from a
// software matrix product at job start and popped as the DUT drains them.
module tb_pe_array_os;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 24;
  localparam int KW   = 8;
  localparam int AWS  = 16;
  localparam int MAXK = 8;
  localparam int LAT  = ROWS + COLS - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic               start = 1'b0;
  logic [KW-1:0]      cfg_k = '0;
  logic               in_valid = 1'b0;
  logic [ROWS*DW-1:0] a_data = '0;
  logic [COLS*DW-1:0] w_data = '0;
  logic               o_ready = 1'b0;
  logic               busy, in_ready, o_valid, o_last;
  logic [COLS*AW-1:0] o_data;

  logic                startS = 1'b0;
  logic [KW-1:0]       cfgKS = '0;
  logic                inValidS = 1'b0;
  logic [ROWS*DW-1:0]  aDataS = '0;
  logic [COLS*DW-1:0]  wDataS = '0;
  logic                oReadyS = 1'b0;
  logic                busyS, inReadyS, oValidS, oLastS;
  logic [COLS*AWS-1:0] oDataS;

  pe_array_os #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_k(cfg_k), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .w_data(w_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last)
  );

  pe_array_os #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AWS), .KW(KW)) dutSmall (
    .clk(clk), .reset(reset), .start(startS), .cfg_k(cfgKS), .busy(busyS),
    .in_valid(inValidS), .in_ready(inReadyS), .a_data(aDataS), .w_data(wDataS),
    .o_valid(oValidS), .o_ready(oReadyS), .o_data(oDataS), .o_last(oLastS)
  );

  always #5 clk = ~clk;

  int matA [ROWS][MAXK];
  int matW [MAXK][COLS];
  logic [COLS*AW-1:0]  expQ [$];
  logic [COLS*AWS-1:0] expSQ [$];
  logic [COLS*AW-1:0]  gotRows [ROWS];
  int passCnt = 0;
  int totalCnt = 0;

  function automatic logic [COLS*AW-1:0] modelRow(input int r, input int k);
    logic signed [AW-1:0] s;
    logic [COLS*AW-1:0] row;
    row = '0;
    for (int c = 0; c < COLS; c++) begin
      s = '0;
      for (int kk = 0; kk < k; kk++) s = s + AW'(matA[r][kk] * matW[kk][c]);
      row[c*AW +: AW] = s;
    end
    return row;
  endfunction

  task automatic fillMats(input int aVal, input int wVal);
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < MAXK; k++) matA[r][k] = aVal;
    for (int k = 0; k < MAXK; k++) for (int c = 0; c < COLS; c++) matW[k][c] = wVal;
  endtask

  task automatic fillIdentity();
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < MAXK; k++) matA[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < MAXK; k++) for (int c = 0; c < COLS; c++) matW[k][c] = 4 * k + c;
  endtask

  // Runs one full job on the main instance; the operand side may insert gaps and the result side a stall.
  task automatic runJob(input int k, input bit gapIn, input bit stallOut, input bit pokeStart, output int beats);
    int idx, cyc, pat, stallLeft;
    bit took, prevStall;
    logic [COLS*AW-1:0] held, want;
    for (int r = 0; r < ROWS; r++) expQ.push_back(modelRow(r, k));
    start = 1'b1;
    cfg_k = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    totalCnt++;
    if (in_ready !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL start_accept: in_ready=%b busy=%b, required 1 and 1", in_ready, busy);
    else passCnt++;
    idx = 0; pat = 0; cyc = 0;
    while (idx < k && cyc < 200) begin
      in_valid = gapIn ? (pat % 3 == 0) : 1'b1;
      if (in_valid) begin
        for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = DW'(matA[r][idx]);
        for (int c = 0; c < COLS; c++) w_data[c*DW +: DW] = DW'(matW[idx][c]);
      end else begin
        a_data = $urandom;
        w_data = $urandom;
      end
      if (pokeStart && idx == 1) begin
        start = 1'b1;
        cfg_k = KW'(1);
      end else start = 1'b0;
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) idx++;
      pat++; cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    totalCnt++;
    if (idx != k) $display("[TB] FAIL beats_accepted: got %0d, required %0d", idx, k);
    else passCnt++;
    totalCnt++;
    if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL flush_entry: in_ready=%b busy=%b, required 0 and 1", in_ready, busy);
    else passCnt++;
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    totalCnt++;
    if (cyc != LAT) $display("[TB] FAIL latency: got %0d edges, required %0d", cyc, LAT);
    else passCnt++;
    beats = 0; cyc = 0; prevStall = 1'b0; held = '0;
    stallLeft = stallOut ? 3 : 0;
    while (beats < ROWS && cyc < 100) begin
      if (prevStall) begin
        totalCnt++;
        if (o_data !== held || o_valid !== 1'b1)
          $display("[TB] FAIL stall_hold: data=%h valid=%b, required %h and 1", o_data, o_valid, held);
        else passCnt++;
      end
      if (stallOut && beats == 2 && stallLeft > 0) begin
        o_ready = 1'b0;
        stallLeft--;
      end else o_ready = 1'b1;
      if (o_valid && o_ready) begin
        want = (expQ.size() > 0) ? expQ.pop_front() : '0;
        totalCnt++;
        if (o_data !== want) $display("[TB] FAIL row%0d_data: got %h, required %h", beats, o_data, want);
        else passCnt++;
        totalCnt++;
        if (o_last !== (beats == ROWS - 1))
          $display("[TB] FAIL row%0d_last: got %b, required %b", beats, o_last, beats == ROWS - 1);
        else passCnt++;
        gotRows[beats] = o_data;
        beats++;
      end
      held = o_data;
      prevStall = o_valid && !o_ready;
      @(posedge clk); #1;
      cyc++;
    end
    o_ready = 1'b0;
    expQ.delete();
    totalCnt++;
    if (beats != ROWS) $display("[TB] FAIL beat_count: got %0d, required %0d", beats, ROWS);
    else passCnt++;
    totalCnt++;
    if (busy !== 1'b0 || o_valid !== 1'b0 || o_last !== 1'b0)
      $display("[TB] FAIL job_end: busy=%b o_valid=%b o_last=%b, required all 0", busy, o_valid, o_last);
    else passCnt++;
  endtask

  task automatic test_reset();
    #2;
    totalCnt++;
    if ({busy, in_ready, o_valid, o_last} !== 4'b0 || o_data !== '0)
      $display("[TB] FAIL reset_outputs: flags=%b data=%h, required 0", {busy, in_ready, o_valid, o_last}, o_data);
    else passCnt++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_k1_basic();
    int beats;
    fillMats(1, 2);
    runJob(1, 1'b0, 1'b0, 1'b0, beats);
  endtask

  task automatic test_identity();
    int beats;
    logic [COLS*AW-1:0] row2;
    fillIdentity();
    runJob(4, 1'b0, 1'b0, 1'b0, beats);
    row2 = {24'd11, 24'd10, 24'd9, 24'd8};
    totalCnt++;
    if (gotRows[2] !== row2) $display("[TB] FAIL identity_row2: got %h, required %h", gotRows[2], row2);
    else passCnt++;
  endtask

  task automatic test_negative();
    int beats;
    fillMats(-128, -128);
    runJob(1, 1'b0, 1'b0, 1'b0, beats);
  endtask

  // The 16-bit accumulator instance: four 127*127 products overflow and must wrap.
  task automatic test_wrap16();
    int cyc, beats;
    logic signed [AWS-1:0] s;
    logic [COLS*AWS-1:0] want, row;
    s = '0;
    for (int k = 0; k < 4; k++) s = s + AWS'(127 * 127);
    for (int c = 0; c < COLS; c++) row[c*AWS +: AWS] = s;
    for (int r = 0; r < ROWS; r++) expSQ.push_back(row);
    startS = 1'b1;
    cfgKS = KW'(4);
    @(posedge clk); #1;
    startS = 1'b0;
    inValidS = 1'b1;
    aDataS = {ROWS{8'sd127}};
    wDataS = {COLS{8'sd127}};
    repeat (4) begin
      @(posedge clk); #1;
    end
    inValidS = 1'b0;
    cyc = 0;
    while (oValidS !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    oReadyS = 1'b1;
    beats = 0;
    while (oValidS === 1'b1 && beats < ROWS) begin
      want = (expSQ.size() > 0) ? expSQ.pop_front() : '0;
      totalCnt++;
      if (oDataS !== want) $display("[TB] FAIL wrap16_row%0d: got %h, required %h", beats, oDataS, want);
      else passCnt++;
      beats++;
      @(posedge clk); #1;
    end
    oReadyS = 1'b0;
    expSQ.delete();
    totalCnt++;
    if (beats != ROWS || busyS !== 1'b0)
      $display("[TB] FAIL wrap16_beats: got %0d beats busy=%b, required %0d and 0", beats, busyS, ROWS);
    else passCnt++;
  endtask

  task automatic test_stalls();
    int beats;
    fillIdentity();
    runJob(4, 1'b1, 1'b1, 1'b0, beats);
  endtask

  task automatic test_cfg_zero();
    bit seenBusy;
    start = 1'b1;
    cfg_k = '0;
    @(posedge clk); #1;
    start = 1'b0;
    seenBusy = 1'b0;
    repeat (4) begin
      if (busy !== 1'b0 || in_ready !== 1'b0) seenBusy = 1'b1;
      @(posedge clk); #1;
    end
    totalCnt++;
    if (seenBusy) $display("[TB] FAIL cfg_zero_ignored: busy went %b, required 0", seenBusy);
    else passCnt++;
  endtask

  task automatic test_start_ignored();
    int beats;
    fillIdentity();
    runJob(4, 1'b0, 1'b0, 1'b1, beats);
  endtask

  task automatic test_back_to_back();
    int beats;
    fillMats(3, -5);
    runJob(2, 1'b0, 1'b0, 1'b0, beats);
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < MAXK; k++) matA[r][k] = r - k;
    for (int k = 0; k < MAXK; k++) for (int c = 0; c < COLS; c++) matW[k][c] = 7 * c - k;
    runJob(3, 1'b0, 1'b0, 1'b0, beats);
  endtask

  // Abort a job while it flushes, then run a fresh job that must show no trace of it.
  task automatic test_reset_flush();
    int beats;
    bit leaked;
    fillMats(9, 9);
    start = 1'b1;
    cfg_k = KW'(1);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    a_data = {ROWS{8'sd9}};
    w_data = {COLS{8'sd9}};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    totalCnt++;
    if ({busy, in_ready, o_valid, o_last} !== 4'b0 || o_data !== '0)
      $display("[TB] FAIL reset_in_flush: flags=%b data=%h, required 0", {busy, in_ready, o_valid, o_last}, o_data);
    else passCnt++;
    @(negedge clk);
    reset = 1'b1;
    leaked = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b0 || busy !== 1'b0) leaked = 1'b1;
    end
    totalCnt++;
    if (leaked) $display("[TB] FAIL abort_no_emit: o_valid or busy seen %b, required 0", leaked);
    else passCnt++;
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < MAXK; k++) matA[r][k] = r + 1;
    for (int k = 0; k < MAXK; k++) for (int c = 0; c < COLS; c++) matW[k][c] = c + 2;
    runJob(1, 1'b0, 1'b0, 1'b0, beats);
  endtask

  initial begin
    test_reset();
    test_k1_basic();
    test_identity();
    test_negative();
    test_wrap16();
    test_stalls();
    test_cfg_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_flush();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/pe_array_os.md
# pe_array_os

Parametrised output-stationary systolic MAC array: `ROWS` × `COLS` processing elements with configurable reduction depth, internal input skewing, a flush/drain state machine and valid/ready handshakes on both the operand and result sides. It is the next-generation compute core for the MAC datapath. It generalises the fixed 4×4 PE group to arbitrary array size and accumulator width, and adds automatic result drain.

## Interface
Parameters:
- `ROWS`, default 4: array rows; one activation lane per row.
- `COLS`, default 4: array columns; one weight lane per column.
- `DW`, default 8: operand width, signed two's complement.
- `AW`, default 24: accumulator width, signed.
- `KW`, default 8: width of the reduction-depth field.

Ports:
- `clk`, input, 1: single clock; all flops rise-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a job; sampled only in IDLE.
- `cfg_k`, input, KW: reduction depth K, latched on an accepted start.
- `busy`, output, 1: high whenever the state is not IDLE.
- `in_valid`, input, 1: operand beat valid.
- `in_ready`, output, 1: high only in COMPUTE.
- `a_data`, input, ROWS*DW: lane r is the activation for row r, in bits [r*DW +: DW].
- `w_data`, input, COLS*DW: lane c is the weight for column c, in bits [c*DW +: DW].
- `o_valid`, output, 1: result row valid.
- `o_ready`, input, 1: downstream accepts the result row.
- `o_data`, output, COLS*AW: lane c is acc[r][c] of the current drain row r.
- `o_last`, output, 1: marks the final result row, r = ROWS-1.

## Operation
- States: IDLE, COMPUTE, FLUSH, DRAIN.
- IDLE:
  - `start`=1 with `cfg_k`≠0: latch K, clear all accumulators, go to COMPUTE.
  - `start` with `cfg_k`=0 is ignored.
- COMPUTE:
  - A beat is accepted on `in_valid & in_ready`.
  - The array advances (global enable) only on an accepted beat; when `in_valid`=0 the array freezes.
  - On acceptance of the K-th beat, go to FLUSH.
- Operand movement:
  - Activation lane r is delayed r enable steps, then shifts right one cell per enable.
  - Weight lane c is delayed c enable steps, then shifts down one cell per enable.
  - Every operand carries a valid tag. Cell (r,c) accumulates acc += a·w only when both tags are set.
  - Result: after K beats, acc[r][c] = Σₖ A[r][k]·W[k][c].
- FLUSH:
  - Enable is forced high for exactly ROWS+COLS-1 cycles with tags cleared at the inputs.
  - Then go to DRAIN.
- DRAIN:
  - Emits ROWS beats, row 0 first; each beat presents all COLS accumulators of row r.
  - The row index advances on `o_valid & o_ready`.
  - After row ROWS-1 is accepted, go to IDLE.
- Arithmetic:
  - The DW×DW signed product is sign-extended to AW.
  - Accumulation wraps modulo 2^AW; there is no saturation.
- `start` while busy is ignored. Accumulators hold their values after DRAIN until the next accepted start.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE; all accumulators, skew and shift registers, tags, counters, K and the drain index clear to 0.
  - `busy`, `in_ready`, `o_valid` and `o_last` are 0, and `o_data` is 0.
- Reset mid-operation aborts the job immediately. No partial result is emitted.
- `in_ready` rises the cycle after the start edge and falls the cycle after the edge that accepts beat K.
- Latency: `o_valid` rises exactly ROWS+COLS-1 edges after the edge accepting beat K (7 at default). The latency is independent of K and of stalls.
- `o_valid` stays high throughout DRAIN. With `o_ready` low, `o_data` and `o_last` hold stable.
- `o_last` = `o_valid` and (row index = ROWS-1).
- Back-to-back jobs: `start` is accepted in the first IDLE cycle after the final drain beat. `busy` drops for at least 1 cycle between jobs.
- Outputs are registered or driven purely from state; there is no combinational path from `in_valid` or `o_ready` to any output.

## Test plan
- K=1, all a=1, all w=2, `o_ready`=1 → 4 beats, every lane = 2; `o_last` set on beat 4; `o_valid` first seen 7 edges after the accept.
- K=4, A = identity, W[k][c] = 4k+c → result row r equals W row r, i.e. row 2 = {11,10,9,8} as lanes 3..0.
- K=1, a=w=-128 → all lanes 16384. Repeat with `AW`=16, K=4 and a=w=127 → lanes wrap to -1020.
- Same data as the identity test with `in_valid` toggled 1,0,0,1,… and `o_ready` low for 3 cycles mid-drain → identical results; `o_data` stable during the stall; beat count stays 4.
- Start with `cfg_k`=0 → `busy` stays 0. Start pulsed again during COMPUTE → ignored; results unchanged.
- Reset asserted during FLUSH → all outputs go to 0 that cycle, state goes to IDLE. A new K=1 job then gives correct results with no residue from the aborted job.
